// File: rtl/gfifo_rd_packer.sv
// Purpose: read-domain consumer of the gray-code async FIFO; packs 4-bit entries LSB-first into words.
// Latency: a word is valid from the edge that captures its last nibble; requests issue one cycle after they qualify.
// Backpressure: a held output word lets the pack register fill, then the credit rule stops FIFO requests.
// Optional feature macro: GFIFO_PACK_ERR_EN (drop unexpected rd_valid pulses and raise a sticky err).
module gfifo_rd_packer #(
  parameter int NIB_PER_WORD = 4
) (
  input  logic                                 rd_clk,
  input  logic                                 rst,
  input  logic                                 empty,
  input  logic                                 rd_valid,
  input  logic [3:0]                           rd_data,
  output logic                                 rd_req_,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [4*NIB_PER_WORD-1:0]            out_data,
  output logic [$clog2(NIB_PER_WORD+1)-1:0]    out_nib_cnt
`ifdef GFIFO_PACK_ERR_EN
  ,
  output logic                                 err
`endif
);

  localparam int OUT_W = 4 * NIB_PER_WORD;
  localparam int CNT_W = $clog2(NIB_PER_WORD + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NIB_PER_WORD);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   outst;
  logic [CNT_W-1:0]   pack_cnt;
  logic [OUT_W-1:0]   pack_reg;

  logic               req_now;
  logic               slot_free;
  logic               take;
  logic               can_req;
  logic               full_xfer;
  logic               flush_xfer;
  logic               load;
  logic [CNT_W-1:0]   outst_nxt;
  logic [CNT_W-1:0]   pack_cnt_a;
  logic [CNT_W-1:0]   pack_cnt_nxt;
  logic [CNT_W:0]     credit_sum;
  logic [OUT_W-1:0]   pack_reg_a;
  logic [OUT_W-1:0]   emit_data;

  // Next-state datapath: credit accounting, nibble capture, word/flush emission decision.
  always_comb begin
    req_now   = !rd_req_;
    slot_free = !out_valid || out_ready;

    // A nibble is never written past a full pack register; a legitimate one cannot
    // arrive then because credits cover pack space.
`ifdef GFIFO_PACK_ERR_EN
    take = rd_valid && ((outst != '0) || req_now) && (pack_cnt != FULL);
`else
    take = rd_valid && (pack_cnt != FULL);
`endif

    // Request and return in the same cycle cancel; an unmatched return saturates at zero.
    outst_nxt = outst;
    if (req_now && !rd_valid) begin
      outst_nxt = outst + CNT_W'(1);
    end else if (!req_now && rd_valid && (outst != '0)) begin
      outst_nxt = outst - CNT_W'(1);
    end

    pack_reg_a = pack_reg;
    pack_cnt_a = pack_cnt;
    if (take) begin
      for (int k = 0; k < NIB_PER_WORD; k++) begin
        if (CNT_W'(k) == pack_cnt) begin
          pack_reg_a[4*k +: 4] = rd_data;
        end
      end
      pack_cnt_a = pack_cnt + CNT_W'(1);
    end

    // Nibbles above the fill level hold stale data from earlier words; zero them.
    emit_data = '0;
    for (int k = 0; k < NIB_PER_WORD; k++) begin
      if (CNT_W'(k) < pack_cnt_a) begin
        emit_data[4*k +: 4] = pack_reg_a[4*k +: 4];
      end
    end

    full_xfer    = (pack_cnt_a == FULL) && slot_free;
    flush_xfer   = (state == FLUSH_EMIT) && slot_free && !full_xfer;
    load         = full_xfer || flush_xfer;
    pack_cnt_nxt = load ? '0 : pack_cnt_a;

    // Credits already spent: entries in flight plus entries waiting in the pack register.
    credit_sum = {1'b0, outst} + {1'b0, pack_cnt};
    can_req    = (state == RUN) && !flush && !empty && rd_req_ &&
                 (credit_sum < (CNT_W+1)'(NIB_PER_WORD));
  end

  // Flush sequencing: stop requesting, drain in-flight entries, then emit any partial word.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (flush) state <= FLUSH_WAIT;
        end
        FLUSH_WAIT: begin
          if (outst == '0) state <= (pack_cnt_nxt == '0) ? RUN : FLUSH_EMIT;
        end
        FLUSH_EMIT: begin
          if (slot_free) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // One-cycle active-low read strobes and the count of reads still awaiting rd_valid.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_req_ <= 1'b1;
      outst   <= '0;
    end else begin
      rd_req_ <= !can_req;
      outst   <= outst_nxt;
    end
  end

  // Pack register and its fill level.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      pack_reg <= '0;
      pack_cnt <= '0;
    end else begin
      pack_reg <= pack_reg_a;
      pack_cnt <= pack_cnt_nxt;
    end
  end

  // Output slot: reload on the accepting edge keeps one word per cycle at the port.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_nib_cnt <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= emit_data;
      out_nib_cnt <= pack_cnt_a;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef GFIFO_PACK_ERR_EN
  // Sticky flag for a return pulse with no read in flight.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (rd_valid && (outst == '0) && !req_now) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gfifo_rd_packer.sv
// Bench for gfifo_rd_packer: behavioural FIFO model plus output scoreboard.
// Table of packing vectors, then hand-written backpressure, reset and error sequences.
// Inputs change at posedge+1; the FIFO model and monitors run on negedge.
module tb_gfifo_rd_packer;

  logic        rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty = 1'b0;
  logic        rd_valid = 1'b0;
  logic [3:0]  rd_data = 4'h0;
  logic        rd_req_;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_nib_cnt;
`ifdef GFIFO_PACK_ERR_EN
  logic        err;
`endif

  always #5 rd_clk = ~rd_clk;

  gfifo_rd_packer #(.NIB_PER_WORD(4)) dut (
    .rd_clk      (rd_clk),
    .rst         (rst),
    .empty       (empty),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_req_     (rd_req_),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_nib_cnt (out_nib_cnt)
`ifdef GFIFO_PACK_ERR_EN
    ,
    .err         (err)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  cnt;
  } word_t;

  typedef struct {
    int         due;
    logic [3:0] d;
  } pend_t;

  typedef struct {
    logic [31:0] nibs;
    int          n;
    bit          do_flush;
    int          lat;
    bit          stall;
    int          n_exp;
    logic [15:0] d0;
    logic [2:0]  c0;
    logic [15:0] d1;
    logic [2:0]  c1;
  } vec_t;

  word_t      exp_q[$];
  logic [3:0] fifo_q[$];
  pend_t      pend_q[$];
  int         acc_cyc[$];

  int   cyc = 0;
  int   lat = 1;
  int   last_due = -1;
  int   n_req = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic prev_req = 1'b1;
  logic hold_ne = 1'b1;
  int   rdy_mode = 0;
  logic rdy_val = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model, request-protocol monitor and output scoreboard.
  always @(negedge rd_clk) begin
    pend_t p;
    cyc++;
    if (!rst) begin
      if (!rd_req_) begin
        n_req++;
        check("req_spacing", 32'(prev_req), 32'd1);
        check("req_while_empty", 32'(empty), 32'd0);
        if (fifo_q.size() != 0) begin
          p.d   = fifo_q.pop_front();
          p.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          last_due = p.due;
          pend_q.push_back(p);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0].data));
          check("out_nib_cnt", 32'(out_nib_cnt), 32'(exp_q[0].cnt));
          if (out_ready) begin
            void'(exp_q.pop_front());
            acc_cyc.push_back(cyc);
          end
        end
      end
      prev_req = rd_req_;
    end else begin
      prev_req = 1'b1;
    end
    rd_valid = 1'b0;
    rd_data  = 4'h0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      rd_valid = 1'b1;
      rd_data  = p.d;
    end
    empty = (fifo_q.size() == 0) && !hold_ne;
  end

  // Downstream ready: held level or random toggling.
  always @(posedge rd_clk) begin
    #1;
    out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((fifo_q.size() != 0 || pend_q.size() != 0) && t < 1000) begin
      tick(1);
      t++;
    end
    check("idle_timeout", 32'(t < 1000), 32'd1);
    tick(3);
  endtask

  task automatic wait_out();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      tick(1);
      t++;
    end
    check("output_timeout", 32'(t < 1000), 32'd1);
    tick(2);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic inject(input logic [3:0] d);
    pend_t p;
    p.d   = d;
    p.due = (cyc + 1 > last_due) ? cyc + 1 : last_due + 1;
    last_due = p.due;
    pend_q.push_back(p);
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [2:0] c);
    word_t w;
    w.data = d;
    w.cnt  = c;
    exp_q.push_back(w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_req_"}, 32'(rd_req_), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_nib_cnt"}, 32'(out_nib_cnt), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   base;
    logic [3:0] nib;

    tbl[0] = '{32'h0000_4321, 4, 1'b0, 1, 1'b0, 1, 16'h4321, 3'd4, 16'h0000, 3'd0};
    tbl[1] = '{32'h0000_0CBA, 3, 1'b1, 2, 1'b0, 1, 16'h0CBA, 3'd3, 16'h0000, 3'd0};
    tbl[2] = '{32'h89AB_CDEF, 8, 1'b0, 0, 1'b1, 2, 16'hCDEF, 3'd4, 16'h89AB, 3'd4};
    tbl[3] = '{32'h0005_4321, 5, 1'b1, 3, 1'b0, 2, 16'h4321, 3'd4, 16'h0005, 3'd1};
    tbl[4] = '{32'h0000_0000, 0, 1'b1, 1, 1'b0, 0, 16'h0000, 3'd0, 16'h0000, 3'd0};
    tbl[5] = '{32'h0000_0076, 2, 1'b1, 1, 1'b1, 1, 16'h0076, 3'd2, 16'h0000, 3'd0};
    tbl[6] = '{32'h0000_F0F0, 4, 1'b0, 2, 1'b0, 1, 16'hF0F0, 3'd4, 16'h0000, 3'd0};

    // Reset with the FIFO reporting data available.
    rst = 1'b1;
    hold_ne = 1'b1;
    tick(2);
    check_reset_outputs("reset");
`ifdef GFIFO_PACK_ERR_EN
    check("reset_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    hold_ne = 1'b0;
    tick(2);

    for (int v = 0; v < 7; v++) begin
      lat = tbl[v].lat;
      rdy_mode = tbl[v].stall ? 1 : 0;
      if (tbl[v].n_exp > 0) push_exp(tbl[v].d0, tbl[v].c0);
      if (tbl[v].n_exp > 1) push_exp(tbl[v].d1, tbl[v].c1);
      for (int i = 0; i < tbl[v].n; i++) begin
        nib = tbl[v].nibs[4*i +: 4];
        fifo_q.push_back(nib);
      end
      wait_idle();
      if (tbl[v].do_flush) pulse_flush();
      wait_out();
      tick(5);
    end
    rdy_mode = 0;
    rdy_val  = 1'b1;

    // Backpressure: first word held, pack fills, requests stop with one entry left.
    lat = 1;
    rdy_val = 1'b0;
    tick(2);
    push_exp(16'h4321, 3'd4);
    push_exp(16'h8765, 3'd4);
    base = n_req;
    for (int i = 1; i <= 9; i++) fifo_q.push_back(4'(i));
    tick(80);
    check("bp_request_count", 32'(n_req - base), 32'd8);
    check("bp_fifo_left", 32'(fifo_q.size()), 32'd1);
    acc_cyc.delete();
    rdy_val = 1'b1;
    wait_out();
    check("bp_accept_count", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) check("bp_back_to_back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    wait_idle();
    push_exp(16'h0009, 3'd1);
    pulse_flush();
    wait_out();

    // Reset after two nibbles discards them.
    fifo_q.push_back(4'h1);
    fifo_q.push_back(4'h2);
    wait_idle();
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midop_reset");
    rst = 1'b0;
    tick(2);
    push_exp(16'h8765, 3'd4);
    for (int i = 5; i <= 8; i++) fifo_q.push_back(4'(i));
    wait_idle();
    wait_out();

    // Return pulse with nothing outstanding.
`ifdef GFIFO_PACK_ERR_EN
    check("err_before_inject", 32'(err), 32'd0);
    inject(4'hD);
    tick(4);
    check("err_set", 32'(err), 32'd1);
    push_exp(16'h4321, 3'd4);
    for (int i = 1; i <= 4; i++) fifo_q.push_back(4'(i));
    wait_idle();
    wait_out();
    check("err_sticky", 32'(err), 32'd1);
`else
    inject(4'hD);
    tick(4);
    push_exp(16'h321D, 3'd4);
    for (int i = 1; i <= 3; i++) fifo_q.push_back(4'(i));
    wait_idle();
    wait_out();
    push_exp(16'h4321, 3'd4);
    for (int i = 1; i <= 4; i++) fifo_q.push_back(4'(i));
    wait_idle();
    wait_out();
`endif

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
